ddr3_wr_issue: RTL and testbench

//  Downstream of the AXI write path. Pairs each queued BL8 write command (addr, id, seq) with

---
 rtl/ddr3_wr_issue_pkg.sv | 13 +
 rtl/ddr3_wr_issue.sv | 146 ++++++++++++++
 tb/tb_ddr3_wr_issue.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_wr_issue_pkg.sv
// Shared DDR3 write-path definitions: BL8 chunk size and the one-hot issue-FSM encoding.
package ddr3_wr_issue_pkg;

    localparam int DDR3_BURST_BYTES = 16;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_DATA = 4'b0100,
        ST_PAD  = 4'b1000
    } wr_state_e;

endpackage

// File: rtl/ddr3_wr_issue.sv
// Pairs each queued BL8 write command with one chunk of write data, padding short bursts
// with zero-strobe beats, and flags command/data framing mismatches.
module ddr3_wr_issue
    import ddr3_wr_issue_pkg::*;
#(
    parameter int ADDRS        = 32,
    parameter int WIDTH        = 32,
    parameter int MASKS        = WIDTH / 8,
    parameter int AXI_ID_WIDTH = 4,
    parameter int BURST_BYTES  = DDR3_BURST_BYTES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_store_i,
    output logic                    mem_accept_o,
    input  logic                    mem_wseq_i,
    input  logic [AXI_ID_WIDTH-1:0] mem_wrid_i,
    input  logic [ADDRS-1:0]        mem_addr_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic                    mem_last_i,
    input  logic [MASKS-1:0]        mem_strb_i,
    input  logic [WIDTH-1:0]        mem_data_i,
    output logic                    ddr_req_o,
    input  logic                    ddr_ack_i,
    output logic [AXI_ID_WIDTH-1:0] ddr_wrid_o,
    output logic [ADDRS-1:0]        ddr_addr_o,
    output logic                    ddr_valid_o,
    input  logic                    ddr_ready_i,
    output logic                    ddr_last_o,
    output logic [MASKS-1:0]        ddr_strb_o,
    output logic [WIDTH-1:0]        ddr_data_o,
    output logic                    err_o
);

    localparam int BEATS = BURST_BYTES / MASKS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    wr_state_e                 state_reg, state_next;
    logic [CNT_W-1:0]          count_reg, count_next;
    logic                      open_reg, open_next;
    logic                      err_reg, err_next;
    logic [ADDRS-1:0]          addr_reg;
    logic [AXI_ID_WIDTH-1:0]   wrid_reg;
    logic                      pop;
    logic                      at_last;

    assign at_last = (count_reg == CNT_LAST);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        open_next   = open_reg;
        err_next    = err_reg;
        pop         = 1'b0;
        ddr_req_o   = 1'b0;
        ddr_valid_o = 1'b0;
        mem_ready_o = 1'b0;
        ddr_last_o  = 1'b0;
        ddr_strb_o  = '0;
        ddr_data_o  = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (mem_store_i) begin
                    pop        = 1'b1;
                    state_next = ST_REQ;
                    // A continuation command must arrive exactly when the previous chunk left a burst open.
                    if (mem_wseq_i != open_reg) begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                ddr_req_o = 1'b1;
                if (ddr_ack_i) begin
                    state_next = ST_DATA;
                    count_next = '0;
                end
            end
            ST_DATA: begin
                ddr_valid_o = mem_valid_i;
                mem_ready_o = ddr_ready_i;
                ddr_strb_o  = mem_strb_i;
                ddr_data_o  = mem_data_i;
                ddr_last_o  = at_last;
                if (mem_valid_i && ddr_ready_i) begin
                    if (at_last) begin
                        state_next = ST_IDLE;
                        count_next = '0;
                        open_next  = !mem_last_i;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                        if (mem_last_i) begin
                            state_next = ST_PAD;
                            open_next  = 1'b0;
                        end
                    end
                end
            end
            ST_PAD: begin
                ddr_valid_o = 1'b1;
                ddr_last_o  = at_last;
                if (ddr_ready_i) begin
                    if (at_last) begin
                        state_next = ST_IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Gated so the pop pulse is also low while reset is held.
    assign mem_accept_o = pop & ~reset;
    assign ddr_addr_o   = addr_reg;
    assign ddr_wrid_o   = wrid_reg;
    assign err_o        = err_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            open_reg  <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wrid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            open_reg  <= open_next;
            err_reg   <= err_next;
            if (pop) begin
                addr_reg <= mem_addr_i;
                wrid_reg <= mem_wrid_i;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_wr_issue.sv
// Self-checking bench for ddr3_wr_issue: directed scenarios plus randomized bursts checked
// against a chunk-level model of the expected DDR3 request and beat streams.
module tb_ddr3_wr_issue;

    localparam int ADDRS = 32;
    localparam int WIDTH = 32;
    localparam int MASKS = 4;
    localparam int IDW   = 4;
    localparam int BEATS = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             mem_store_i;
    logic             mem_accept_o;
    logic             mem_wseq_i;
    logic [IDW-1:0]   mem_wrid_i;
    logic [ADDRS-1:0] mem_addr_i;
    logic             mem_valid_i;
    logic             mem_ready_o;
    logic             mem_last_i;
    logic [MASKS-1:0] mem_strb_i;
    logic [WIDTH-1:0] mem_data_i;
    logic             ddr_req_o;
    logic             ddr_ack_i;
    logic [IDW-1:0]   ddr_wrid_o;
    logic [ADDRS-1:0] ddr_addr_o;
    logic             ddr_valid_o;
    logic             ddr_ready_i;
    logic             ddr_last_o;
    logic [MASKS-1:0] ddr_strb_o;
    logic [WIDTH-1:0] ddr_data_o;
    logic             err_o;

    ddr3_wr_issue #(
        .ADDRS(ADDRS), .WIDTH(WIDTH), .MASKS(MASKS), .AXI_ID_WIDTH(IDW), .BURST_BYTES(16)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_store_i(mem_store_i), .mem_accept_o(mem_accept_o), .mem_wseq_i(mem_wseq_i),
        .mem_wrid_i(mem_wrid_i), .mem_addr_i(mem_addr_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_last_i(mem_last_i),
        .mem_strb_i(mem_strb_i), .mem_data_i(mem_data_i),
        .ddr_req_o(ddr_req_o), .ddr_ack_i(ddr_ack_i), .ddr_wrid_o(ddr_wrid_o), .ddr_addr_o(ddr_addr_o),
        .ddr_valid_o(ddr_valid_o), .ddr_ready_i(ddr_ready_i), .ddr_last_o(ddr_last_o),
        .ddr_strb_o(ddr_strb_o), .ddr_data_o(ddr_data_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Pending stimulus.
    logic [31:0] cmd_addr_q[$];
    logic [3:0]  cmd_id_q[$];
    bit          cmd_seq_q[$];
    logic [31:0] din_data_q[$];
    logic [3:0]  din_strb_q[$];
    bit          din_last_q[$];
    // Model expectations.
    logic [31:0] exp_req_addr_q[$];
    logic [3:0]  exp_req_id_q[$];
    bit          exp_seq_q[$];
    bit          exp_cont_q[$];
    logic [31:0] exp_b_data_q[$];
    logic [3:0]  exp_b_strb_q[$];
    bit          exp_b_last_q[$];
    bit          exp_b_pad_q[$];
    bit          exp_err;
    // Observations.
    logic [31:0] obs_req_addr_q[$];
    logic [3:0]  obs_req_id_q[$];
    int          obs_req_lat_q[$];
    int          obs_req_len_q[$];
    logic [31:0] obs_b_data_q[$];
    logic [3:0]  obs_b_strb_q[$];
    bit          obs_b_last_q[$];
    bit          obs_b_mrdy_q[$];

    // Stimulus knobs and driver state.
    int store_pct, valid_pct, ready_mode, ack_delay;
    bit store_on, valid_on, req_prev;
    int cyc, accept_cyc, req_start, req_run;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One command per BL8 chunk; the burst is split into chunks and the tail padded.
    task automatic gen_burst(input int len, input logic [31:0] base, input int id, input int flip);
        int nch;
        bit s;
        logic [31:0] a, d;
        logic [3:0] cid, st;
        nch = (len + BEATS - 1) / BEATS;
        for (int k = 0; k < nch; k++) begin
            s = (k > 0);
            if (k == flip) s = !s;
            a = base + 32'(16 * k);
            cid = (id < 0) ? 4'($urandom_range(15)) : 4'(id);
            cmd_addr_q.push_back(a);
            cmd_id_q.push_back(cid);
            cmd_seq_q.push_back(s);
            exp_req_addr_q.push_back(a);
            exp_req_id_q.push_back(cid);
            exp_seq_q.push_back(s);
            exp_cont_q.push_back(k > 0);
        end
        for (int j = 0; j < nch * BEATS; j++) begin
            if (j < len) begin
                d  = $urandom;
                st = 4'($urandom);
                din_data_q.push_back(d);
                din_strb_q.push_back(st);
                din_last_q.push_back(j == len - 1);
                exp_b_data_q.push_back(d);
                exp_b_strb_q.push_back(st);
                exp_b_pad_q.push_back(1'b0);
            end else begin
                exp_b_data_q.push_back(32'h0);
                exp_b_strb_q.push_back(4'h0);
                exp_b_pad_q.push_back(1'b1);
            end
            exp_b_last_q.push_back((j % BEATS) == BEATS - 1);
        end
    endtask

    // One clock: drive at +1, sample settled outputs at +2.
    task automatic step();
        @(posedge clock);
        #1;
        if (!store_on && cmd_addr_q.size() > 0 && int'($urandom_range(99)) < store_pct) store_on = 1'b1;
        mem_store_i = store_on;
        if (store_on) begin
            mem_addr_i = cmd_addr_q[0];
            mem_wrid_i = cmd_id_q[0];
            mem_wseq_i = cmd_seq_q[0];
        end else begin
            mem_addr_i = $urandom;
            mem_wrid_i = 4'($urandom);
            mem_wseq_i = 1'($urandom);
        end
        if (!valid_on && din_data_q.size() > 0 && int'($urandom_range(99)) < valid_pct) valid_on = 1'b1;
        mem_valid_i = valid_on;
        if (valid_on) begin
            mem_data_i = din_data_q[0];
            mem_strb_i = din_strb_q[0];
            mem_last_i = din_last_q[0];
        end else begin
            mem_data_i = $urandom;
            mem_strb_i = 4'($urandom);
            mem_last_i = 1'($urandom);
        end
        case (ready_mode)
            1:       ddr_ready_i = 1'b1;
            2:       ddr_ready_i = (cyc % 2 == 0);
            default: ddr_ready_i = 1'($urandom);
        endcase
        if (ack_delay == 0) ddr_ack_i = 1'($urandom);
        else                ddr_ack_i = ddr_req_o && (req_run + 1 >= ack_delay);
        #1;
        cyc++;
        if (mem_accept_o) begin
            chk("accept_only_with_store", 64'(mem_store_i), 64'(1));
            if (store_on) begin
                void'(cmd_addr_q.pop_front());
                void'(cmd_id_q.pop_front());
                void'(cmd_seq_q.pop_front());
                accept_cyc = cyc;
                store_on = 1'b0;
            end
        end
        if (mem_valid_i && mem_ready_o) begin
            void'(din_data_q.pop_front());
            void'(din_strb_q.pop_front());
            void'(din_last_q.pop_front());
            valid_on = 1'b0;
        end
        if (ddr_req_o) begin
            if (!req_prev) req_start = cyc;
            req_run++;
        end
        if (ddr_req_o && ddr_ack_i) begin
            obs_req_addr_q.push_back(ddr_addr_o);
            obs_req_id_q.push_back(ddr_wrid_o);
            obs_req_lat_q.push_back(req_start - accept_cyc);
            obs_req_len_q.push_back(req_run);
            req_run = 0;
        end
        if (ddr_valid_o && ddr_ready_i) begin
            obs_b_data_q.push_back(ddr_data_o);
            obs_b_strb_q.push_back(ddr_strb_o);
            obs_b_last_q.push_back(ddr_last_o);
            obs_b_mrdy_q.push_back(mem_ready_o);
        end
        req_prev = ddr_req_o;
    endtask

    task automatic clear_all();
        cmd_addr_q.delete(); cmd_id_q.delete(); cmd_seq_q.delete();
        din_data_q.delete(); din_strb_q.delete(); din_last_q.delete();
        exp_req_addr_q.delete(); exp_req_id_q.delete(); exp_seq_q.delete(); exp_cont_q.delete();
        exp_b_data_q.delete(); exp_b_strb_q.delete(); exp_b_last_q.delete(); exp_b_pad_q.delete();
        obs_req_addr_q.delete(); obs_req_id_q.delete(); obs_req_lat_q.delete(); obs_req_len_q.delete();
        obs_b_data_q.delete(); obs_b_strb_q.delete(); obs_b_last_q.delete(); obs_b_mrdy_q.delete();
    endtask

    task automatic check_results(input string name);
        int nr, nb;
        chk({name, " req_count"}, 64'(obs_req_addr_q.size()), 64'(exp_req_addr_q.size()));
        chk({name, " beat_count"}, 64'(obs_b_data_q.size()), 64'(exp_b_data_q.size()));
        nr = (obs_req_addr_q.size() < exp_req_addr_q.size()) ? obs_req_addr_q.size() : exp_req_addr_q.size();
        nb = (obs_b_data_q.size() < exp_b_data_q.size()) ? obs_b_data_q.size() : exp_b_data_q.size();
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("%s req%0d addr", name, i), 64'(obs_req_addr_q[i]), 64'(exp_req_addr_q[i]));
            chk($sformatf("%s req%0d id", name, i), 64'(obs_req_id_q[i]), 64'(exp_req_id_q[i]));
            chk($sformatf("%s req%0d latency", name, i), 64'(obs_req_lat_q[i]), 64'(1));
            if (ack_delay > 0)
                chk($sformatf("%s req%0d req_cycles", name, i), 64'(obs_req_len_q[i]), 64'(ack_delay));
        end
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s beat%0d data", name, i), 64'(obs_b_data_q[i]), 64'(exp_b_data_q[i]));
            chk($sformatf("%s beat%0d strb", name, i), 64'(obs_b_strb_q[i]), 64'(exp_b_strb_q[i]));
            chk($sformatf("%s beat%0d last", name, i), 64'(obs_b_last_q[i]), 64'(exp_b_last_q[i]));
            chk($sformatf("%s beat%0d mem_ready", name, i), 64'(obs_b_mrdy_q[i]), 64'(!exp_b_pad_q[i]));
        end
        while (exp_seq_q.size() > 0) begin
            if (exp_seq_q[0] != exp_cont_q[0]) exp_err = 1'b1;
            void'(exp_seq_q.pop_front());
            void'(exp_cont_q.pop_front());
        end
        chk({name, " err_o"}, 64'(err_o), 64'(exp_err));
        clear_all();
    endtask

    task automatic run_scenario(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (cmd_addr_q.size() == 0) && (din_data_q.size() == 0) &&
                   (obs_b_data_q.size() >= exp_b_data_q.size()) &&
                   (obs_req_addr_q.size() >= exp_req_addr_q.size());
        end
        chk({name, " completes_in_budget"}, 64'(done), 64'(1));
        repeat (3) step();
        check_results(name);
    endtask

    task automatic check_zero(input string name);
        chk({name, " mem_accept_o"}, 64'(mem_accept_o), 64'(0));
        chk({name, " mem_ready_o"},  64'(mem_ready_o),  64'(0));
        chk({name, " ddr_req_o"},    64'(ddr_req_o),    64'(0));
        chk({name, " ddr_wrid_o"},   64'(ddr_wrid_o),   64'(0));
        chk({name, " ddr_addr_o"},   64'(ddr_addr_o),   64'(0));
        chk({name, " ddr_valid_o"},  64'(ddr_valid_o),  64'(0));
        chk({name, " ddr_last_o"},   64'(ddr_last_o),   64'(0));
        chk({name, " ddr_strb_o"},   64'(ddr_strb_o),   64'(0));
        chk({name, " ddr_data_o"},   64'(ddr_data_o),   64'(0));
        chk({name, " err_o"},        64'(err_o),        64'(0));
    endtask

    task automatic reset_driver();
        store_on = 1'b0; valid_on = 1'b0; req_prev = 1'b0;
        req_run = 0; accept_cyc = 0; req_start = 0;
        mem_store_i = 1'b0; mem_wseq_i = 1'b0; mem_wrid_i = '0; mem_addr_i = '0;
        mem_valid_i = 1'b0; mem_last_i = 1'b0; mem_strb_i = '0; mem_data_i = '0;
        ddr_ack_i = 1'b0; ddr_ready_i = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cyc = 0;
        reset_driver();
        store_pct = 100; valid_pct = 100; ready_mode = 1; ack_delay = 2;

        repeat (3) @(posedge clock);
        #2;
        check_zero("in_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        step();
        check_zero("after_reset");

        // Single command, 4 beats, ack on the second request cycle.
        gen_burst(4, 32'h100, 3, -1);
        run_scenario("single_cmd", 200);

        // Two-chunk burst: continuation command carries seq 1.
        ack_delay = 0;
        gen_burst(8, 32'h200, -1, -1);
        run_scenario("two_chunks", 300);

        // Short bursts are padded; the next burst's data is pending during the pad.
        ready_mode = 1;
        gen_burst(2, 32'h300, 5, -1);
        gen_burst(3, 32'h340, -1, -1);
        run_scenario("pad", 300);

        // Alternating controller ready, gapped write data.
        ready_mode = 2; valid_pct = 40; store_pct = 50;
        gen_burst(6, 32'h400, -1, -1);
        gen_burst(5, 32'h500, -1, -1);
        run_scenario("toggle_ready", 600);

        // Continuation command with no open burst raises the sticky error.
        ready_mode = 0; valid_pct = 70; store_pct = 80;
        gen_burst(4, 32'h600, -1, 0);
        run_scenario("framing_err", 300);

        for (int r = 0; r < 6; r++) begin
            store_pct  = int'($urandom_range(30, 100));
            valid_pct  = int'($urandom_range(30, 100));
            ready_mode = int'($urandom_range(0, 2));
            ack_delay  = int'($urandom_range(0, 3));
            gen_burst(int'($urandom_range(1, 11)), 32'h1000 + 32'(r * 32'h100), -1, -1);
            gen_burst(int'($urandom_range(1, 11)), 32'h8000 + 32'(r * 32'h100), -1, -1);
            run_scenario($sformatf("random%0d", r), 1500);
        end

        // Reset in DATA after two beats of a chunk.
        ready_mode = 1; valid_pct = 100; store_pct = 100; ack_delay = 1;
        gen_burst(4, 32'h700, 6, -1);
        n = 0;
        while (obs_b_data_q.size() < 2 && n < 100) begin
            step();
            n++;
        end
        chk("mid_reset reached_two_beats", 64'(obs_b_data_q.size()), 64'(2));
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem_store_i = 1'b1;
        #1;
        check_zero("mid_reset");
        clear_all();
        reset_driver();
        @(posedge clock);
        #1 reset = 1'b0;
        gen_burst(4, 32'h800, 2, -1);
        run_scenario("after_mid_reset", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
